// File: rtl/muldiv_seq_if.sv
// Handshake and result bus of the sequential multiply/divide unit.
interface muldiv_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_seq.sv
// Sequential radix-2 multiply/divide unit: one iteration per clock,
// WIDTH iterations, then a sign-fix cycle. op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    muldiv_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e           r_state;
    logic [CntW-1:0]  r_cnt;
    logic             r_is_div;
    logic             r_neg_q;     // product / quotient negative
    logic             r_neg_r;     // remainder negative (follows dividend)
    logic [WIDTH-1:0] r_acc_hi;    // product high half / partial remainder
    logic [WIDTH-1:0] r_acc_lo;    // multiplier -> product low / dividend -> quotient
    logic [WIDTH-1:0] r_opb;       // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_busy;
    logic             r_done;
    logic             r_div_zero;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_div_by_zero;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_diff;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Operand magnitudes and per-iteration datapath.
    always_comb begin
        w_a_neg       = ~bus.op[0] & bus.a[WIDTH-1];
        w_b_neg       = ~bus.op[0] & bus.b[WIDTH-1];
        w_a_mag       = w_a_neg ? (WIDTH'(0) - bus.a) : bus.a;
        w_b_mag       = w_b_neg ? (WIDTH'(0) - bus.b) : bus.b;
        w_div_by_zero = bus.op[1] & (bus.b == '0);

        // Shift-add: add multiplicand when the current multiplier bit is set.
        w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : '0);

        // Restoring divide: remainder fits in WIDTH bits whenever the trial succeeds.
        w_div_shift = {r_acc_hi, r_acc_lo[WIDTH-1]};
        w_div_ok    = w_div_shift >= {1'b0, r_opb};
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_opb;

        w_prod_fix = r_neg_q ? ((2*WIDTH)'(0) - {r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
        w_quot_fix = r_neg_q ? (WIDTH'(0) - r_acc_lo) : r_acc_lo;
        w_rem_fix  = r_neg_r ? (WIDTH'(0) - r_acc_hi) : r_acc_hi;
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_opb      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        if (w_div_by_zero) begin
                            // Flag only; stay idle and keep hi/lo.
                            r_done     <= 1'b1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            r_acc_hi <= '0;
                            r_acc_lo <= w_a_mag;
                            r_opb    <= w_b_mag;
                            r_cnt    <= CntW'(WIDTH - 1);
                            r_busy   <= 1'b1;
                            r_state  <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_div_ok ? w_div_diff : w_div_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_div_ok};
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    if (r_cnt == '0) begin
                        r_state <= StFix;
                    end else begin
                        r_cnt <= r_cnt - CntW'(1);
                    end
                end
                StFix: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quot_fix;
                    end else begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_div_zero;
    assign bus.hi       = r_hi;
    assign bus.lo       = r_lo;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (WIDTH=32) against an arithmetic reference model.
module tb_muldiv_seq;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    muldiv_seq_if #(.WIDTH(32)) bus ();

    muldiv_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on 64-bit values; returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     q;
        logic [63:0]     r;
        case (op)
            2'b00: return sa * sb;
            2'b01: return ua * ub;
            2'b10: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request (caller sits at a negedge), pass E0, then scramble inputs.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        {exp_hi, exp_lo} = model(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.op    = 2'($urandom);
    endtask

    // Wait for done (bounded), checking busy length and the result; ends at the done negedge.
    task automatic finish_op(input string tag);
        int busy_cnt = 0;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
            else if (bus.busy) busy_cnt++;
        end
        check($sformatf("%s/done_seen", tag), 64'(seen), 64'd1);
        check($sformatf("%s/busy_cycles", tag), 64'(busy_cnt), 64'd33);
        check($sformatf("%s/hi", tag), 64'(bus.hi), 64'(exp_hi));
        check($sformatf("%s/lo", tag), 64'(bus.lo), 64'(exp_lo));
        check($sformatf("%s/div_zero", tag), 64'(bus.div_zero), 64'd0);
        check($sformatf("%s/busy_at_done", tag), 64'(bus.busy), 64'd0);
    endtask

    // One idle cycle: done must have dropped and results must hold.
    task automatic settle(input string tag);
        @(negedge clk);
        check($sformatf("%s/done_pulse", tag), 64'(bus.done), 64'd0);
        check($sformatf("%s/idle_busy", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s/hold", tag), {bus.hi, bus.lo}, {exp_hi, exp_lo});
    endtask

    task automatic div_zero_op(input string tag, input logic [1:0] op, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = 32'd0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.b     = $urandom;
        @(negedge clk);
        check($sformatf("%s/done", tag), 64'(bus.done), 64'd1);
        check($sformatf("%s/flag", tag), 64'(bus.div_zero), 64'd1);
        check($sformatf("%s/busy", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s/hold", tag), {bus.hi, bus.lo}, {exp_hi, exp_lo});
        @(negedge clk);
        check($sformatf("%s/done_drop", tag), 64'(bus.done), 64'd0);
        check($sformatf("%s/flag_drop", tag), 64'(bus.div_zero), 64'd0);
        check($sformatf("%s/busy2", tag), 64'(bus.busy), 64'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          busy_hits;
        int          done_hits;

        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;

        // Reset state.
        #12;
        check("reset/busy", 64'(bus.busy), 64'd0);
        check("reset/done", 64'(bus.done), 64'd0);
        check("reset/div_zero", 64'(bus.div_zero), 64'd0);
        check("reset/hilo", {bus.hi, bus.lo}, 64'd0);

        // First start accepted on the first edge after release.
        @(negedge clk);
        reset = 1'b1;
        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
        finish_op("mult_neg");
        settle("mult_neg");

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max");
        settle("multu_max");

        issue(2'b10, 32'hFFFF_FFF9, 32'd2);
        finish_op("div_neg");
        settle("div_neg");

        issue(2'b11, 32'd100, 32'd7);
        finish_op("divu_small");
        settle("divu_small");

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf");
        settle("div_ovf");

        // Set hi/lo to 0x1234/0x5678, then divide by zero.
        issue(2'b11, 32'h5678_1234, 32'h0001_0000);
        finish_op("divu_prep");
        check("divu_prep/values", {bus.hi, bus.lo}, 64'h0000_1234_0000_5678);
        div_zero_op("divu_zero", 2'b11, 32'd55);
        div_zero_op("div_zero", 2'b10, 32'h8000_0000);

        // Back-to-back: start in the done cycle is accepted.
        issue(2'b00, 32'h8000_0000, 32'h8000_0000);
        finish_op("b2b_first");
        issue(2'b10, 32'd7, 32'hFFFF_FFFE);
        finish_op("b2b_second");
        settle("b2b_second");

        // Randomized ops, biased toward sign/magnitude corner values.
        for (int n = 0; n < 24; n++) begin
            r_op = 2'($urandom);
            case ($urandom_range(0, 4))
                0: r_a = 32'h8000_0000;
                1: r_a = 32'h7FFF_FFFF;
                default: r_a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0: r_b = 32'hFFFF_FFFF;
                1: r_b = 32'd1;
                2: r_b = $urandom_range(1, 20);
                default: r_b = $urandom;
            endcase
            if (r_op[1] && r_b == 32'd0) r_b = 32'd3;
            issue(r_op, r_a, r_b);
            finish_op($sformatf("rand%0d_op%0d", n, r_op));
            settle($sformatf("rand%0d", n));
        end

        // Reset at E10 of a MULT with start held high.
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = $urandom;
        bus.b     = $urandom;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midreset/busy", 64'(bus.busy), 64'd0);
        check("midreset/done", 64'(bus.done), 64'd0);
        check("midreset/hilo", {bus.hi, bus.lo}, 64'd0);
        done_hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_hits++;
        end
        check("midreset/no_done", 64'(done_hits), 64'd0);
        reset = 1'b1;
        issue(2'b00, 32'hFFFF_FF00, 32'h0001_0001);
        finish_op("postreset");
        settle("postreset");
        busy_hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.busy || bus.done) busy_hits++;
        end
        check("postreset/single_op", 64'(busy_hits), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
